// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder block.
package half_adder_pkg;

  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned CNT_W_MAX = 32;

  // Number of set bits in a lane vector, zero-extended to WIDTH_MAX.
  function automatic int unsigned popcount(input logic [WIDTH_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes behind a one-deep valid/ready output register.
// Optional saturating carry-event counter enabled by HALF_ADDER_CARRY_CNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_param
    $error("half_adder: WIDTH or CNT_W out of legal range");
  end

  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_cout;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (lane_sum[i]),
      .cout (lane_cout[i])
    );
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic             accept;

  // Slot frees up in the same cycle the consumer drains it.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      valid_d = 1'b1;
      sum_d   = lane_sum;
      cout_d  = lane_cout;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam logic [63:0] CntMax = (64'd1 << CNT_W) - 64'd1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      cnt_sum;

  // Add in 64 bits so the saturation compare never sees a wrapped value.
  always_comb begin
    cnt_sum = 64'(cnt_q) + 64'(popcount(WIDTH_MAX'(lane_cout)));
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = (cnt_sum > CntMax) ? CntMax[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: randomized and directed operands vs. an arithmetic lane model.
module tb_half_adder;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic [W-1:0] cout;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

  half_adder #(
    .WIDTH (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
  } exp_t;

  exp_t         q[$];
  int           checks   = 0;
  int           failures = 0;
  int           cnt_exp  = 0;
  logic [W-1:0] last_s   = '0;
  logic [W-1:0] last_c   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each lane adds two one-bit numbers: sum is the low bit, carry the high bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      int t;
      t = (x[i] ? 1 : 0) + (y[i] ? 1 : 0);
      e.s[i] = (t % 2) == 1;
      e.c[i] = (t / 2) == 1;
    end
    return e;
  endfunction

  function automatic int carries(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if ((x[i] ? 1 : 0) + (y[i] ? 1 : 0) == 2) n++;
    return n;
  endfunction

  // Stimulus side: record each accepted pair just before the edge that takes it.
  always @(negedge clk) begin
    #1;
    if (!rst && in_valid && in_ready) begin
      int lim;
      q.push_back(model(a, b));
      lim     = (1 << CNT_W) - 1;
      cnt_exp = cnt_exp + carries(a, b);
      if (cnt_exp > lim) cnt_exp = lim;
    end
  end

  // Monitor: compare DUT outputs against the head of the scoreboard every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_v;
      exp_v = q.size() != 0;
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("in_ready", 64'(in_ready), 64'(!exp_v || out_ready));
      if (exp_v) begin
        check("sum", 64'(sum), 64'(q[0].s));
        check("cout", 64'(cout), 64'(q[0].c));
        if (out_ready) begin
          last_s = q[0].s;
          last_c = q[0].c;
          void'(q.pop_front());
        end
      end else begin
        check("sum_hold", 64'(sum), 64'(last_s));
        check("cout_hold", 64'(cout), 64'(last_c));
      end
`ifdef HALF_ADDER_CARRY_CNT_EN
      check("carry_cnt", 64'(carry_cnt), 64'(cnt_exp));
`endif
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = x;
    b         = y;
    out_ready = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check({tag, "_carry_cnt"}, 64'(carry_cnt), 64'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pa [6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'hA5};
    logic [W-1:0] pb [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hCC, 8'h3C};

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Truth table on every lane, then mixed-lane patterns.
    for (int i = 0; i < 6; i++) drive(1'b1, pa[i], pb[i], 1'b1);
    drive(1'b0, 8'h5A, 8'h5A, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);

    // Backpressure: one result held while further operands are offered.
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b0);
    drive(1'b1, 8'h0F, 8'h33, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);

    // Back-to-back stream.
    for (int i = 0; i < 4; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
            ($urandom_range(0, 9) < 7));
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    cnt_exp = 0;
    last_s  = '0;
    last_c  = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Carry counter: 8 carries, then saturation.
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 8'h01, 8'h01, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("carry_cnt_saturated", 64'(carry_cnt), 64'd15);
`endif

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
